// File: rtl/unpack_window_ctrl.sv
// Unpack window sequencer: holds a two-beat {win_hi, win_lo} window and issues one
// window+cursor+lane-mask group per downstream handshake. Optional counters: UNPACK_STATS_EN.
module unpack_window_ctrl #(
  parameter int BEAT_W       = 256,
  parameter int FIELD_W      = 8,
  parameter int LANES        = 8,
  parameter int START_OFFSET = 175,
  parameter int CUR_W        = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BEAT_W-1:0]     s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  output logic [2*BEAT_W-1:0]   m_window,
  output logic [CUR_W-1:0]      m_cursor,
  output logic [LANES-1:0]      m_lane_en,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef UNPACK_STATS_EN
  ,
  output logic [31:0]           stat_groups,
  output logic [31:0]           stat_stall_cycles
`endif
);

  localparam int GROUP = LANES * FIELD_W;
  localparam logic [CUR_W-1:0] BEAT_C  = CUR_W'(BEAT_W);
  localparam logic [CUR_W-1:0] GROUP_C = CUR_W'(GROUP);
  localparam logic [CUR_W-1:0] START_C = CUR_W'(START_OFFSET);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BEAT_W-1:0]  win_lo_q, win_lo_d;
  logic [BEAT_W-1:0]  win_hi_q, win_hi_d;
  logic               last_seen_q, last_seen_d;
  logic [CUR_W-1:0]   cursor_q, cursor_d;

  logic [CUR_W-1:0]   nxt;
  logic               wrap;
  logic               ready_raw;
  logic               s_fire;
  logic               m_fire;

  assign nxt      = cursor_q + GROUP_C;
  assign wrap     = (nxt >= BEAT_C);
  assign s_tready = ready_raw && !rst;
  assign s_fire   = s_tvalid && s_tready;
  assign m_fire   = m_valid && m_ready;
  assign m_cursor = cursor_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d     = state_q;
    win_lo_d    = win_lo_q;
    win_hi_d    = win_hi_q;
    last_seen_d = last_seen_q;
    cursor_d    = cursor_q;
    ready_raw   = 1'b0;
    m_valid     = 1'b0;
    m_window    = '0;
    m_lane_en   = '0;
    m_last      = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_raw = 1'b1;
        if (s_fire) begin
          win_lo_d = s_tdata;
          cursor_d = START_C;
          state_d  = s_tlast ? DRAIN : FILL;
        end
      end

      FILL: begin
        ready_raw = 1'b1;
        if (s_fire) begin
          win_hi_d    = s_tdata;
          last_seen_d = s_tlast;
          state_d     = RUN;
        end
      end

      RUN: begin
        m_valid   = 1'b1;
        m_window  = {win_hi_q, win_lo_q};
        m_lane_en = '1;
        // Refill is offered only on the cycle the window shifts, giving a bubble-free handoff.
        ready_raw = m_ready && wrap && !last_seen_q;
        if (m_fire) begin
          if (!wrap) begin
            cursor_d = nxt;
          end else begin
            win_lo_d = win_hi_q;
            cursor_d = nxt - BEAT_C;
            if (last_seen_q) begin
              state_d = DRAIN;
            end else if (s_tvalid) begin
              win_hi_d    = s_tdata;
              last_seen_d = s_tlast;
            end else begin
              state_d = FILL;
            end
          end
        end
      end

      DRAIN: begin
        m_valid  = 1'b1;
        m_window = {{BEAT_W{1'b0}}, win_lo_q};
        for (int i = 0; i < LANES; i++) begin
          m_lane_en[i] = ((cursor_q + CUR_W'((i + 1) * FIELD_W)) <= BEAT_C);
        end
        m_last = wrap;
        if (m_fire) begin
          if (wrap) begin
            last_seen_d = 1'b0;
            state_d     = IDLE;
          end else begin
            cursor_d = nxt;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= IDLE;
      win_lo_q    <= '0;
      win_hi_q    <= '0;
      last_seen_q <= 1'b0;
      cursor_q    <= START_C;
    end else begin
      state_q     <= state_d;
      win_lo_q    <= win_lo_d;
      win_hi_q    <= win_hi_d;
      last_seen_q <= last_seen_d;
      cursor_q    <= cursor_d;
    end
  end

`ifdef UNPACK_STATS_EN
  logic [31:0] groups_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      groups_q <= '0;
      stall_q  <= '0;
    end else begin
      if (m_fire) groups_q <= groups_q + 32'd1;
      // Stall counter saturates rather than wrapping.
      if (m_valid && !m_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign stat_groups       = groups_q;
  assign stat_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_unpack_window_ctrl.sv
// Directed-vector bench for unpack_window_ctrl with hand-computed cursor, mask and window values.
module tb_unpack_window_ctrl;

  localparam int BW = 256;

  logic           clk = 1'b0;
  logic           rst;
  logic [BW-1:0]  s_tdata;
  logic           s_tvalid;
  logic           s_tlast;
  logic           s_tready;
  logic [2*BW-1:0] m_window;
  logic [9:0]     m_cursor;
  logic [7:0]     m_lane_en;
  logic           m_last;
  logic           m_valid;
  logic           m_ready;

  int vectors     = 0;
  int miscompares = 0;

  logic [BW-1:0] b [6];

  unpack_window_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .s_tdata   (s_tdata),
    .s_tvalid  (s_tvalid),
    .s_tlast   (s_tlast),
    .s_tready  (s_tready),
    .m_window  (m_window),
    .m_cursor  (m_cursor),
    .m_lane_en (m_lane_en),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are then sampled 1-2 time units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_ready = 1'b0; s_tdata = '0;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  // Offer one beat and let one edge take it (used only from IDLE/FILL where s_tready is 1).
  task automatic push_beat(input logic [BW-1:0] d, input logic last);
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_tvalid = 1'b1; s_tlast = 1'b0; m_ready = 1'b0; s_tdata = b[0];
    for (int c = 0; c < 2; c++) begin
      step();
      vectors++;
      if (s_tready !== 1'b0) begin miscompares++; $display("FAIL reset_s_tready cyc%0d got %b want 0", c, s_tready); end
      vectors++;
      if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid cyc%0d got %b want 0", c, m_valid); end
      vectors++;
      if (m_cursor !== 10'd175) begin miscompares++; $display("FAIL reset_m_cursor cyc%0d got %0d want 175", c, m_cursor); end
      vectors++;
      if (m_lane_en !== 8'h00 || m_last !== 1'b0 || m_window !== '0) begin
        miscompares++; $display("FAIL reset_outputs cyc%0d lane_en %h last %b window_nonzero %b want 00/0/0", c, m_lane_en, m_last, |m_window);
      end
    end
    rst = 1'b0; s_tvalid = 1'b0;
    #1;
    vectors++;
    if (s_tready !== 1'b1) begin miscompares++; $display("FAIL idle_s_tready got %b want 1", s_tready); end
  endtask

  task automatic test_three_beat();
    int unsigned    exp_cur [10] = '{175, 239, 47, 111, 175, 239, 47, 111, 175, 239};
    logic [2*BW-1:0] exp_win;
    logic           exp_rdy;
    logic           fire;
    reset_dut();
    m_ready = 1'b1;
    push_beat(b[0], 1'b0);
    push_beat(b[1], 1'b0);
    s_tdata = b[2]; s_tlast = 1'b1; s_tvalid = 1'b1;
    #1;
    for (int g = 0; g < 10; g++) begin
      if (g < 2)      exp_win = {b[1], b[0]};
      else if (g < 6) exp_win = {b[2], b[1]};
      else            exp_win = {{BW{1'b0}}, b[2]};
      exp_rdy = (g == 1);
      vectors++;
      if (m_valid !== 1'b1 || m_cursor !== 10'(exp_cur[g])) begin
        miscompares++; $display("FAIL tb3_cursor g%0d valid %b cursor %0d want 1/%0d", g, m_valid, m_cursor, exp_cur[g]);
      end
      vectors++;
      if (m_lane_en !== ((g == 9) ? 8'h03 : 8'hFF) || m_last !== (g == 9)) begin
        miscompares++; $display("FAIL tb3_mask g%0d lane_en %h last %b want %h/%b", g, m_lane_en, m_last, (g == 9) ? 8'h03 : 8'hFF, g == 9);
      end
      vectors++;
      if (m_window !== exp_win) begin miscompares++; $display("FAIL tb3_window g%0d got %h want %h", g, m_window, exp_win); end
      vectors++;
      if (s_tready !== exp_rdy) begin miscompares++; $display("FAIL tb3_s_tready g%0d got %b want %b", g, s_tready, exp_rdy); end
      fire = s_tvalid && s_tready;
      step();
      if (fire) begin s_tvalid = 1'b0; s_tlast = 1'b0; end
      #1;
    end
    vectors++;
    if (m_valid !== 1'b0 || s_tready !== 1'b1) begin
      miscompares++; $display("FAIL tb3_back_to_idle valid %b s_tready %b want 0/1", m_valid, s_tready);
    end
  endtask

  task automatic test_single_beat();
    reset_dut();
    m_ready = 1'b1;
    push_beat(b[3], 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_cursor !== 10'd175 || m_lane_en !== 8'hFF || m_last !== 1'b0) begin
      miscompares++; $display("FAIL single_g0 valid %b cursor %0d lane_en %h last %b want 1/175/ff/0", m_valid, m_cursor, m_lane_en, m_last);
    end
    vectors++;
    if (m_window[2*BW-1:BW] !== '0 || m_window[BW-1:0] !== b[3]) begin
      miscompares++; $display("FAIL single_window got %h want %h", m_window, {{BW{1'b0}}, b[3]});
    end
    step();
    vectors++;
    if (m_valid !== 1'b1 || m_cursor !== 10'd239 || m_lane_en !== 8'h03 || m_last !== 1'b1) begin
      miscompares++; $display("FAIL single_g1 valid %b cursor %0d lane_en %h last %b want 1/239/03/1", m_valid, m_cursor, m_lane_en, m_last);
    end
    step();
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_done valid got %b want 0", m_valid); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    m_ready = 1'b1;
    push_beat(b[0], 1'b0);
    push_beat(b[1], 1'b0);
    step();
    m_ready = 1'b0;
    s_tdata = b[2]; s_tlast = 1'b1; s_tvalid = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      vectors++;
      if (m_valid !== 1'b1 || m_cursor !== 10'd239 || m_lane_en !== 8'hFF || m_last !== 1'b0 || m_window !== {b[1], b[0]}) begin
        miscompares++; $display("FAIL bp_frozen c%0d valid %b cursor %0d lane_en %h last %b want 1/239/ff/0", c, m_valid, m_cursor, m_lane_en, m_last);
      end
      vectors++;
      if (s_tready !== 1'b0) begin miscompares++; $display("FAIL bp_s_tready c%0d got %b want 0", c, s_tready); end
      step();
    end
    m_ready = 1'b1;
    #1;
    vectors++;
    if (s_tready !== 1'b1) begin miscompares++; $display("FAIL bp_release_s_tready got %b want 1", s_tready); end
    step();
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    vectors++;
    if (m_valid !== 1'b1 || m_cursor !== 10'd47 || m_window !== {b[2], b[1]}) begin
      miscompares++; $display("FAIL bp_refill valid %b cursor %0d want 1/47 window_ok %b", m_valid, m_cursor, m_window === {b[2], b[1]});
    end
  endtask

  task automatic test_starvation();
    reset_dut();
    m_ready = 1'b1;
    push_beat(b[0], 1'b0);
    push_beat(b[1], 1'b0);
    step();
    step();
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (m_valid !== 1'b0 || s_tready !== 1'b1 || m_cursor !== 10'd47) begin
        miscompares++; $display("FAIL starve_fill c%0d valid %b s_tready %b cursor %0d want 0/1/47", c, m_valid, s_tready, m_cursor);
      end
      if (c < 2) step();
    end
    push_beat(b[2], 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_cursor !== 10'd47 || m_window !== {b[2], b[1]}) begin
      miscompares++; $display("FAIL starve_resume valid %b cursor %0d want 1/47 window_ok %b", m_valid, m_cursor, m_window === {b[2], b[1]});
    end
  endtask

  task automatic test_midstream_reset();
    reset_dut();
    m_ready = 1'b1;
    push_beat(b[0], 1'b0);
    push_beat(b[1], 1'b0);
    step();
    rst = 1'b1;
    step();
    vectors++;
    if (m_valid !== 1'b0 || s_tready !== 1'b0 || m_cursor !== 10'd175 || m_lane_en !== 8'h00 || m_last !== 1'b0 || m_window !== '0) begin
      miscompares++; $display("FAIL mid_reset valid %b s_tready %b cursor %0d lane_en %h last %b want 0/0/175/00/0", m_valid, s_tready, m_cursor, m_lane_en, m_last);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (s_tready !== 1'b1 || m_valid !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset_idle s_tready %b valid %b want 1/0", s_tready, m_valid);
    end
    push_beat(b[4], 1'b0);
    push_beat(b[5], 1'b1);
    vectors++;
    if (m_valid !== 1'b1 || m_cursor !== 10'd175 || m_window !== {b[5], b[4]}) begin
      miscompares++; $display("FAIL mid_restart valid %b cursor %0d want 1/175 window_ok %b", m_valid, m_cursor, m_window === {b[5], b[4]});
    end
  endtask

  initial begin
    for (int k = 0; k < 6; k++) b[k] = {8{32'hC0DE_0000 | 32'(k * 32'h0101 + 1)}};
    test_reset();
    test_three_beat();
    test_single_beat();
    test_backpressure();
    test_starvation();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
